// File: rtl/mem_arbiter_if.sv
// Shared-memory port bundle between the two caches, the arbiter and main memory.
// The arbiter uses the slave view; the environment (caches + memory) uses master.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH  = 28,
   parameter int BLOCK_WIDTH = 128
);
   logic                   I_READ;
   logic [ADDR_WIDTH-1:0]  I_ADDRESS;
   logic [BLOCK_WIDTH-1:0] I_READDATA;
   logic                   I_BUSYWAIT;

   logic                   D_READ;
   logic                   D_WRITE;
   logic [ADDR_WIDTH-1:0]  D_ADDRESS;
   logic [BLOCK_WIDTH-1:0] D_WRITEDATA;
   logic [BLOCK_WIDTH-1:0] D_READDATA;
   logic                   D_BUSYWAIT;

   logic                   MEM_READ;
   logic                   MEM_WRITE;
   logic [ADDR_WIDTH-1:0]  MEM_ADDRESS;
   logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA;
   logic [BLOCK_WIDTH-1:0] MEM_READDATA;
   logic                   MEM_BUSYWAIT;

   modport slave (
      input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
             MEM_READDATA, MEM_BUSYWAIT,
      output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
             MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );

   modport master (
      output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
             MEM_READDATA, MEM_BUSYWAIT,
      input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
             MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between I-cache and D-cache.
// IDLE -> ACCESS (>= 2 cycles) -> RELEASE (1 cycle, requester's BUSYWAIT low) -> IDLE.
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 28,
   parameter int BLOCK_WIDTH = 128
) (
   input  logic          CLK,
   input  logic          RESET,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
   typedef enum logic {GNT_I, GNT_D} grant_t;

   state_t                 state_q;
   grant_t                 grant_q;
   grant_t                 last_grant_q;
   logic                   first_q;
   logic                   mem_read_q;
   logic                   mem_write_q;
   logic [ADDR_WIDTH-1:0]  mem_addr_q;
   logic [BLOCK_WIDTH-1:0] mem_wdata_q;
   logic [BLOCK_WIDTH-1:0] i_rdata_q;
   logic [BLOCK_WIDTH-1:0] d_rdata_q;

   logic i_req;
   logic d_req;
   logic pick_d;

   assign i_req  = bus.I_READ;
   assign d_req  = bus.D_READ | bus.D_WRITE;
   // D wins when alone, or on a conflict when I was served last.
   assign pick_d = d_req & (~i_req | (last_grant_q == GNT_I));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         grant_q      <= GNT_D;
         last_grant_q <= GNT_I;
         first_q      <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_req | d_req) begin
                  state_q <= ACCESS;
                  first_q <= 1'b1;
                  if (pick_d) begin
                     grant_q      <= GNT_D;
                     last_grant_q <= GNT_D;
                     mem_addr_q   <= bus.D_ADDRESS;
                     if (bus.D_WRITE) begin
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= bus.D_WRITEDATA;
                     end else begin
                        mem_read_q  <= 1'b1;
                     end
                  end else begin
                     grant_q      <= GNT_I;
                     last_grant_q <= GNT_I;
                     mem_addr_q   <= bus.I_ADDRESS;
                     mem_read_q   <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // Memory raises BUSYWAIT combinationally from our strobe, so the
               // first ACCESS cycle would see a stale value and is skipped.
               if (first_q) begin
                  first_q <= 1'b0;
               end else if (!bus.MEM_BUSYWAIT) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  state_q     <= RELEASE;
                  if (mem_read_q) begin
                     if (grant_q == GNT_D) d_rdata_q <= bus.MEM_READDATA;
                     else                  i_rdata_q <= bus.MEM_READDATA;
                  end
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.MEM_READ      = mem_read_q;
   assign bus.MEM_WRITE     = mem_write_q;
   assign bus.MEM_ADDRESS   = mem_addr_q;
   assign bus.MEM_WRITEDATA = mem_wdata_q;
   assign bus.I_READDATA    = i_rdata_q;
   assign bus.D_READDATA    = d_rdata_q;
   assign bus.I_BUSYWAIT    = i_req & ~((state_q == RELEASE) & (grant_q == GNT_I));
   assign bus.D_BUSYWAIT    = d_req & ~((state_q == RELEASE) & (grant_q == GNT_D));
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a latency-programmable memory plus a
// transaction-level model (round-robin order, memory image, cache data copies).
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int BW = 128;
   localparam logic [BW-1:0] PATTERN = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();
   mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int mem_lat = 0;
   int mem_cnt = 0;
   logic [BW-1:0] mem_store [16];

   // Reference model state
   logic [BW-1:0] ref_mem [16];
   logic [BW-1:0] ref_i;
   logic [BW-1:0] ref_d;
   bit            ref_last_d;

   function automatic logic [BW-1:0] init_word(input int i);
      logic [31:0] w;
      if (i == 0) return PATTERN;
      w = 32'hA000_0000 | 32'(i);
      return {w, ~w, w ^ 32'h5555_5555, w + 32'd7};
   endfunction

   // Memory image reloads on reset; busy for mem_lat cycles after the strobe rises.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem_store[i] <= init_word(i);
         mem_cnt <= 0;
      end else if (bus.MEM_READ || bus.MEM_WRITE) begin
         if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT)
            mem_store[bus.MEM_ADDRESS[3:0]] <= bus.MEM_WRITEDATA;
         mem_cnt <= mem_cnt + 1;
      end else begin
         mem_cnt <= 0;
      end
   end

   assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (mem_cnt < mem_lat);
   assign bus.MEM_READDATA = mem_store[bus.MEM_ADDRESS[3:0]];

   task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serve one requester to completion, then drop its request on the RELEASE edge.
   task automatic serve(input bit is_d);
      bit            exp_wr;
      bit            prev;
      bit            done;
      bit            busy;
      bit            other_req;
      logic [AW-1:0] a;
      logic [BW-1:0] wd;
      exp_wr = is_d && bus.D_WRITE;
      a      = is_d ? bus.D_ADDRESS : bus.I_ADDRESS;
      wd     = bus.D_WRITEDATA;
      ref_last_d = is_d;
      if (exp_wr)    ref_mem[a[3:0]] = wd;
      else if (is_d) ref_d = ref_mem[a[3:0]];
      else           ref_i = ref_mem[a[3:0]];
      prev = bus.MEM_READ | bus.MEM_WRITE;
      done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if ((bus.MEM_READ | bus.MEM_WRITE) && !prev) begin
            check_val("mem_write", BW'(bus.MEM_WRITE), BW'(exp_wr));
            check_val("mem_read", BW'(bus.MEM_READ), BW'(!exp_wr));
            check_val("mem_addr", BW'(bus.MEM_ADDRESS), BW'(a));
            if (exp_wr) check_val("mem_wdata", bus.MEM_WRITEDATA, wd);
         end
         prev = bus.MEM_READ | bus.MEM_WRITE;
         busy = is_d ? bus.D_BUSYWAIT : bus.I_BUSYWAIT;
         if (!busy) begin
            check_val("i_rdata", bus.I_READDATA, ref_i);
            check_val("d_rdata", bus.D_READDATA, ref_d);
            other_req = is_d ? bus.I_READ : (bus.D_READ | bus.D_WRITE);
            if (other_req)
               check_val("other_busy", BW'(is_d ? bus.I_BUSYWAIT : bus.D_BUSYWAIT), BW'(1));
            done = 1'b1;
            break;
         end
      end
      if (!done) check_val("release_timeout", BW'(0), BW'(1));
      $display("xfer %s %s addr=%h lat=%0d", is_d ? "D" : "I", exp_wr ? "WR" : "RD", a, mem_lat);
      tick();
      if (is_d) begin
         bus.D_READ  = 1'b0;
         bus.D_WRITE = 1'b0;
      end else begin
         bus.I_READ  = 1'b0;
      end
   endtask

   task automatic do_round(input bit i_rd, input bit d_rd, input bit d_wr);
      bit first_d;
      bus.I_ADDRESS   = AW'($urandom);
      bus.D_ADDRESS   = AW'($urandom);
      bus.D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      bus.I_READ      = i_rd;
      bus.D_READ      = d_rd;
      bus.D_WRITE     = d_wr;
      if (i_rd && (d_rd || d_wr)) begin
         first_d = !ref_last_d;
         serve(first_d);
         serve(!first_d);
      end else if (i_rd) begin
         serve(1'b0);
      end else if (d_rd || d_wr) begin
         serve(1'b1);
      end
   endtask

   initial begin
      logic [AW-1:0] fa;
      bit            seen;
      rst             = 1'b1;
      bus.I_READ      = 1'b1;
      bus.I_ADDRESS   = 28'h0000010;
      bus.D_READ      = 1'b0;
      bus.D_WRITE     = 1'b0;
      bus.D_ADDRESS   = '0;
      bus.D_WRITEDATA = '0;
      mem_lat         = 6;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_i      = '0;
      ref_d      = '0;
      ref_last_d = 1'b0;

      // Reset held two cycles with a live I request
      tick();
      tick();
      check_val("rst_mem_read", BW'(bus.MEM_READ), BW'(0));
      check_val("rst_mem_write", BW'(bus.MEM_WRITE), BW'(0));
      check_val("rst_i_rdata", bus.I_READDATA, '0);
      check_val("rst_d_rdata", bus.D_READDATA, '0);
      check_val("rst_i_busy", BW'(bus.I_BUSYWAIT), BW'(1));
      rst = 1'b0;
      tick();
      check_val("post_rst_read", BW'(bus.MEM_READ), BW'(1));
      check_val("post_rst_addr", BW'(bus.MEM_ADDRESS), BW'(28'h0000010));
      $display("xfer I RD addr=%h started after reset", bus.MEM_ADDRESS);

      // Reset while memory is still busy abandons the transfer
      tick();
      rst        = 1'b1;
      bus.I_READ = 1'b0;
      tick();
      check_val("midrst_read", BW'(bus.MEM_READ), BW'(0));
      check_val("midrst_write", BW'(bus.MEM_WRITE), BW'(0));
      check_val("midrst_i_rdata", bus.I_READDATA, '0);
      check_val("midrst_d_rdata", bus.D_READDATA, '0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_last_d = 1'b0;
      tick();

      // Lone I read, memory busy 3 cycles
      mem_lat       = 3;
      bus.I_ADDRESS = 28'h0000010;
      bus.I_READ    = 1'b1;
      serve(1'b0);
      check_val("lone_i_pattern", bus.I_READDATA, PATTERN);

      // Conflicts (round-robin order comes from the model), then D read+write together
      mem_lat = 2;
      do_round(1'b1, 1'b0, 1'b1);
      do_round(1'b1, 1'b0, 1'b1);
      do_round(1'b0, 1'b1, 1'b1);

      // I read flushed in its second ACCESS cycle while D read becomes pending
      mem_lat       = 4;
      fa            = AW'($urandom);
      bus.I_ADDRESS = fa;
      bus.I_READ    = 1'b1;
      ref_last_d    = 1'b0;
      ref_i         = ref_mem[fa[3:0]];
      seen          = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.MEM_READ) begin
            seen = 1'b1;
            break;
         end
      end
      check_val("flush_strobe_seen", BW'(seen), BW'(1));
      check_val("flush_addr", BW'(bus.MEM_ADDRESS), BW'(fa));
      tick();
      bus.I_READ      = 1'b0;
      bus.D_READ      = 1'b1;
      bus.D_ADDRESS   = AW'($urandom);
      @(negedge clk);
      check_val("flush_i_busy", BW'(bus.I_BUSYWAIT), BW'(0));
      check_val("flush_read_held", BW'(bus.MEM_READ), BW'(1));
      check_val("flush_d_busy", BW'(bus.D_BUSYWAIT), BW'(1));
      $display("xfer I RD addr=%h flushed", fa);
      serve(1'b1);

      // Randomized traffic
      for (int r = 0; r < 40; r++) begin
         int p;
         p       = int'($urandom_range(0, 5));
         mem_lat = int'($urandom_range(0, 5));
         case (p)
            0: do_round(1'b1, 1'b0, 1'b0);
            1: do_round(1'b0, 1'b1, 1'b0);
            2: do_round(1'b0, 1'b0, 1'b1);
            3: do_round(1'b0, 1'b1, 1'b1);
            4: do_round(1'b1, 1'b1, 1'b0);
            default: do_round(1'b1, 1'b0, 1'b1);
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
